// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the timed intersection phase scheduler.
// Holds the phase encoding, the lamp-vector bit positions, the lamp
// patterns for each phase and a small helper used for parameter math.
package traffic_pkg;

  // Phase encoding; also driven out on the debug 'phase' port.
  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED_A = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    ALLRED_B = 3'd5,
    PED_WALK = 3'd6
  } phase_e;

  // Which street held the most recent green; picks the green after a walk.
  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  // Bit positions in the lamp vector.
  localparam int A_RED = 5;
  localparam int A_YEL = 4;
  localparam int A_GRN = 3;
  localparam int B_RED = 2;
  localparam int B_YEL = 1;
  localparam int B_GRN = 0;

  // Lamp patterns {a_red, a_yel, a_grn, b_red, b_yel, b_grn}.
  localparam logic [5:0] LED_A_GREEN  = 6'b001100;
  localparam logic [5:0] LED_A_YELLOW = 6'b010100;
  localparam logic [5:0] LED_ALL_RED  = 6'b100100;
  localparam logic [5:0] LED_PED_WALK = 6'b100100;
  localparam logic [5:0] LED_B_GREEN  = 6'b100001;
  localparam logic [5:0] LED_B_YELLOW = 6'b100010;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Lamp pattern for a phase; an unknown code shows the reset pattern.
  function automatic logic [5:0] led_for(input phase_e p);
    logic [5:0] l;
    case (p)
      A_GREEN:  l = LED_A_GREEN;
      A_YELLOW: l = LED_A_YELLOW;
      ALLRED_A: l = LED_ALL_RED;
      B_GREEN:  l = LED_B_GREEN;
      B_YELLOW: l = LED_B_YELLOW;
      ALLRED_B: l = LED_ALL_RED;
      PED_WALK: l = LED_PED_WALK;
      default:  l = LED_A_GREEN;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// Free-running timing-tick generator.
// Ports: clk (rising edge), reset (async, active low), tick (high for one
// cycle out of every TICK_DIV; first tick in cycle TICK_DIV after release).
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and next tick; tick is registered from the next count so it
  // coincides with the cycle in which the count sits at TICK_DIV-1.
  always_comb begin
    if (cnt_q == PW'(TICK_DIV - 1)) begin
      cnt_d = {PW{1'b0}};
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
    tick_d = (cnt_d == PW'(TICK_DIV - 1));
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= {PW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Timed phase scheduler for a two-street intersection with a pedestrian
// crossing. Enforces minimum/maximum green, yellow and all-red clearance,
// and serves a latched pedestrian request with a walk phase.
// Ports: clk, reset (async, active low), sa/sb (car sensors, level),
// ped_req (button, one-cycle pulse is enough), led (6-bit lamp vector),
// phase (current phase code), ped_walk (walk lamp).
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 8,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int PED       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sa,
  input  logic       sb,
  input  logic       ped_req,
  output logic [5:0] led,
  output logic [2:0] phase,
  output logic       ped_walk
);

  // The phase timer never needs to count past the longest duration.
  localparam int SAT = max2(max2(MAX_GREEN, PED), max2(YELLOW, ALL_RED));
  localparam int EW  = $clog2(SAT + 1);

  logic          tick;
  phase_e        state_q, state_d;
  side_e         last_side_q, last_side_d;
  logic [EW-1:0] elapsed_q, elapsed_d, elapsed_next;
  logic          ped_pending_q, ped_pending_d;
  logic [5:0]    led_q, led_d;
  logic [2:0]    phase_q, phase_d;
  logic          ped_walk_q, ped_walk_d;
  logic          min_ok, max_ok;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Saturating phase-timer increment and the green hold limits.
  always_comb begin
    if (elapsed_q == EW'(SAT)) begin
      elapsed_next = elapsed_q;
    end else begin
      elapsed_next = elapsed_q + EW'(1);
    end
    min_ok = (elapsed_next >= EW'(MIN_GREEN));
    max_ok = (elapsed_next >= EW'(MAX_GREEN));
  end

  // Next phase and side memory; all timed moves happen on a tick, while an
  // unknown state code falls back to A_GREEN at once.
  always_comb begin
    state_d     = state_q;
    last_side_d = last_side_q;
    case (state_q)
      A_GREEN: begin
        // A keeps green while it still has cars, up to MAX_GREEN.
        if (tick && min_ok && (sb || ped_pending_q) && (!sa || max_ok)) begin
          state_d = A_YELLOW;
        end else begin
          state_d = A_GREEN;
        end
      end
      A_YELLOW: begin
        if (tick && (elapsed_next == EW'(YELLOW))) begin
          state_d = ALLRED_A;
        end else begin
          state_d = A_YELLOW;
        end
      end
      ALLRED_A: begin
        if (tick && (elapsed_next == EW'(ALL_RED))) begin
          state_d     = ped_pending_q ? PED_WALK : B_GREEN;
          last_side_d = SIDE_A;
        end else begin
          state_d = ALLRED_A;
        end
      end
      B_GREEN: begin
        if (tick && min_ok && (sa || ped_pending_q) && (!sb || max_ok)) begin
          state_d = B_YELLOW;
        end else begin
          state_d = B_GREEN;
        end
      end
      B_YELLOW: begin
        if (tick && (elapsed_next == EW'(YELLOW))) begin
          state_d = ALLRED_B;
        end else begin
          state_d = B_YELLOW;
        end
      end
      ALLRED_B: begin
        if (tick && (elapsed_next == EW'(ALL_RED))) begin
          state_d     = ped_pending_q ? PED_WALK : A_GREEN;
          last_side_d = SIDE_B;
        end else begin
          state_d = ALLRED_B;
        end
      end
      PED_WALK: begin
        // Hand green to the street that did not have it before the walk.
        if (tick && (elapsed_next == EW'(PED))) begin
          state_d = (last_side_q == SIDE_A) ? B_GREEN : A_GREEN;
        end else begin
          state_d = PED_WALK;
        end
      end
      default: begin
        state_d = A_GREEN;
      end
    endcase
  end

  // Phase timer, pedestrian latch and the output decode of the next phase.
  always_comb begin
    if (state_d != state_q) begin
      elapsed_d = {EW{1'b0}};
    end else if (tick) begin
      elapsed_d = elapsed_next;
    end else begin
      elapsed_d = elapsed_q;
    end

    // Entering the walk clears the latch even if the button is pressed now.
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end else begin
      ped_pending_d = ped_pending_q;
    end

    // Outputs are registered from the next phase so they track the phase
    // register with no added latency.
    led_d      = led_for(state_d);
    phase_d    = state_d;
    ped_walk_d = (state_d == PED_WALK);
  end

  // State, timer, latch and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= A_GREEN;
      last_side_q   <= SIDE_A;
      elapsed_q     <= {EW{1'b0}};
      ped_pending_q <= 1'b0;
      led_q         <= LED_A_GREEN;
      phase_q       <= A_GREEN;
      ped_walk_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_side_q   <= last_side_d;
      elapsed_q     <= elapsed_d;
      ped_pending_q <= ped_pending_d;
      led_q         <= led_d;
      phase_q       <= phase_d;
      ped_walk_q    <= ped_walk_d;
    end
  end

  assign led      = led_q;
  assign phase    = phase_q;
  assign ped_walk = ped_walk_q;

endmodule
